// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and defaults for the 8N1 receiver/transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    // Mid-bit sample point, counted from the start-bit detect tick
    localparam int UART_SAMPLE_IDX = UART_OVERSAMPLE / 2 - 1;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer with asynchronous reset to RESET_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : Oversampled 8N1 UART receiver with mid-bit sampling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 frame_err
);

    localparam int c_cnt_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w = $clog2(DATA_BITS + 1);

    localparam logic [c_cnt_w-1:0] c_sample_idx = c_cnt_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max    = c_cnt_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0] c_last_bit   = c_bit_w'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_state_t          r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_done;
    logic                 r_frame_err;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_dout      <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // Completion pulse lasts one clk regardless of tick spacing
            r_done <= 1'b0;
            if (tick) begin
                case (r_state)
                    IDLE: begin
                        if (!w_rx_s) begin
                            r_state <= START;
                            r_cnt   <= '0;
                        end
                    end
                    START: begin
                        if (r_cnt != c_sample_idx) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_cnt     <= '0;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    DATA: begin
                        if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            r_cnt     <= '0;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_last_bit) begin
                                r_state <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_dout      <= r_shift;
                            r_frame_err <= ~w_rx_s;
                            r_done      <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed, table-driven bench for uart_rx (8N1, 16x ticks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    int n_vec  = 0;
    int n_miss = 0;

    uart_rx #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // One tick every fourth clk
    initial begin
        int tdiv = 0;
        forever begin
            @(negedge clk);
            tick = (tdiv == 3);
            tdiv = (tdiv + 1) % 4;
        end
    end

    int tick_cnt = 0;
    always @(posedge clk) if (tick) tick_cnt <= tick_cnt + 1;

    logic [7:0] q_dout[$];
    logic       q_err[$];
    int         q_tick[$];
    always @(negedge clk) begin
        if (rx_done_tick) begin
            q_dout.push_back(dout);
            q_err.push_back(frame_err);
            q_tick.push_back(tick_cnt);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick) k++;
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_dout;
        logic       exp_err;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   p0;
        int   t0;

        vecs = '{
            '{8'hA5, 1'b1, 8'hA5, 1'b0},
            '{8'h3C, 1'b0, 8'h3C, 1'b1},
            '{8'h81, 1'b1, 8'h81, 1'b0},
            '{8'h00, 1'b1, 8'h00, 1'b0},
            '{8'h6E, 1'b1, 8'h6E, 1'b0}
        };

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_dout", 32'(dout), 32'h00);
        check("reset_done", 32'(rx_done_tick), 32'h0);
        check("reset_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        wait_ticks(1);
        wait_ticks(200);
        check("idle_no_pulse", 32'(q_dout.size()), 32'd0);
        check("idle_dout", 32'(dout), 32'h00);

        // Table-driven frames separated by idle time
        for (int v = 0; v < 5; v++) begin
            p0 = q_dout.size();
            t0 = tick_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            rx = 1'b1;
            wait_ticks(20);
            check($sformatf("vec%0d_pulses", v), 32'(q_dout.size() - p0), 32'd1);
            if (q_dout.size() > p0) begin
                check($sformatf("vec%0d_dout", v), 32'(q_dout[p0]), 32'(vecs[v].exp_dout));
                check($sformatf("vec%0d_err", v), 32'(q_err[p0]), 32'(vecs[v].exp_err));
                check($sformatf("vec%0d_latency", v), 32'(q_tick[p0] - t0), 32'd153);
            end
            check($sformatf("vec%0d_idle", v), 32'(dut.r_state), 32'(IDLE));
        end

        // Break: rx held low yields zero frames with framing error
        p0 = q_dout.size();
        rx = 1'b0;
        wait_ticks(310);
        rx = 1'b1;
        wait_ticks(30);
        check("break_pulses", 32'(q_dout.size() - p0), 32'd2);
        if (q_dout.size() >= p0 + 2) begin
            check("break0_dout", 32'(q_dout[p0]), 32'h00);
            check("break0_err", 32'(q_err[p0]), 32'h1);
            check("break1_dout", 32'(q_dout[p0+1]), 32'h00);
            check("break1_err", 32'(q_err[p0+1]), 32'h1);
        end

        // Back-to-back frames with no idle gap
        p0 = q_dout.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        rx = 1'b1;
        wait_ticks(20);
        check("b2b_pulses", 32'(q_dout.size() - p0), 32'd2);
        if (q_dout.size() >= p0 + 2) begin
            check("b2b_first", 32'(q_dout[p0]), 32'h00);
            check("b2b_second", 32'(q_dout[p0+1]), 32'hFF);
            check("b2b_err", 32'({q_err[p0], q_err[p0+1]}), 32'h0);
            check("b2b_spacing", 32'(q_tick[p0+1] - q_tick[p0]), 32'd160);
        end

        // Glitch: 4 ticks low is rejected at the start-bit midpoint
        p0 = q_dout.size();
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(6);
        check("glitch_idle", 32'(dut.r_state), 32'(IDLE));
        wait_ticks(40);
        check("glitch_pulses", 32'(q_dout.size() - p0), 32'd0);
        check("glitch_dout", 32'(dout), 32'hFF);

        // Reset during data bit 3 of 0x96
        p0 = q_dout.size();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b0;
        wait_ticks(8);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dout", 32'(dout), 32'h00);
        check("midrst_err", 32'(frame_err), 32'h0);
        check("midrst_done", 32'(rx_done_tick), 32'h0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(200);
        check("midrst_no_pulse", 32'(q_dout.size() - p0), 32'd0);
        t0 = tick_cnt;
        send_frame(8'h5A, 1'b1);
        rx = 1'b1;
        wait_ticks(20);
        check("after_rst_pulses", 32'(q_dout.size() - p0), 32'd1);
        if (q_dout.size() > p0) begin
            check("after_rst_dout", 32'(q_dout[p0]), 32'h5A);
            check("after_rst_err", 32'(q_err[p0]), 32'h0);
            check("after_rst_latency", 32'(q_tick[p0] - t0), 32'd153);
        end
        check("held_dout", 32'(dout), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
